// File: rtl/rgmii_pkg.sv
// Shared types and default timing constants for the RGMII speed controller.
package rgmii_pkg;

    // Default debounce, drain, reset and settle lengths, in clk_i cycles.
    localparam int unsigned STABLE_CYCLES_DEF = 16;
    localparam int unsigned DRAIN_TIMEOUT_DEF = 4096;
    localparam int unsigned RST_CYCLES_DEF    = 8;
    localparam int unsigned SETTLE_CYCLES_DEF = 8;

    typedef enum logic [2:0] {
        StLinkDown,
        StActive,
        StDrain,
        StReset,
        StSettle
    } rgmii_state_e;

    // Largest of three values; sizes the shared phase counter.
    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/rgmii_status_debounce.sv
// Debounces the 2-bit PHY status {link_up, speed_1000m}. The count restarts at 1 on any
// change and saturates at STABLE_CYCLES; stable_o is high while the count is saturated.
module rgmii_status_debounce
    import rgmii_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_DEF
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] data_i,
    output logic       stable_o,
    output logic [1:0] value_o
);

    localparam int unsigned CntW = $clog2(STABLE_CYCLES + 1);

    logic [1:0]      prev_q;
    logic [CntW-1:0] cnt_q, cnt_d;

    // Count consecutive cycles with unchanged status, saturating at the threshold.
    always_comb begin
        cnt_d = cnt_q;
        if (data_i != prev_q) begin
            cnt_d = CntW'(1);
        end else if (cnt_q != CntW'(STABLE_CYCLES)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Status history and counter registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prev_q <= 2'b00;
            cnt_q  <= '0;
        end else begin
            prev_q <= data_i;
            cnt_q  <= cnt_d;
        end
    end

    assign stable_o = (cnt_q == CntW'(STABLE_CYCLES));
    assign value_o  = prev_q;

endmodule

// File: rtl/rgmii_speed_ctrl.sv
// RGMII speed-change controller: waits for a debounced link/speed status, drains traffic,
// pulses the datapath reset, lets clocks settle, then re-enables traffic.
module rgmii_speed_ctrl
    import rgmii_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_DEF,
    parameter int unsigned DRAIN_TIMEOUT = DRAIN_TIMEOUT_DEF,
    parameter int unsigned RST_CYCLES    = RST_CYCLES_DEF,
    parameter int unsigned SETTLE_CYCLES = SETTLE_CYCLES_DEF
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic link_up_i,
    input  logic speed_1000m_i,
    input  logic tx_busy_i,
    input  logic rx_busy_i,
    output logic sel_1000m_o,
    output logic dp_rst_o,
    output logic tx_hold_o,
    output logic change_done_o,
    output logic drain_timeout_o
);

    localparam int unsigned PhaseMax = max3(DRAIN_TIMEOUT, RST_CYCLES, SETTLE_CYCLES);
    localparam int unsigned PhaseW   = $clog2(PhaseMax + 1);

    rgmii_state_e      state_q, state_d;
    logic [PhaseW-1:0] phase_q, phase_d;
    logic              drain_to;

    logic              deb_stable;
    logic [1:0]        deb_value;
    logic              deb_link;
    logic              deb_speed;

    logic              sel_d, dp_rst_d, tx_hold_d, change_done_d, drain_timeout_d;

    rgmii_status_debounce #(
        .STABLE_CYCLES(STABLE_CYCLES)
    ) u_debounce (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .data_i  ({link_up_i, speed_1000m_i}),
        .stable_o(deb_stable),
        .value_o (deb_value)
    );

    assign deb_link  = deb_value[1];
    assign deb_speed = deb_value[0];

    // State and phase counter registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StLinkDown;
            phase_q <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
        end
    end

    // Next-state decode; a raw link drop overrides everything outside LINK_DOWN.
    always_comb begin
        state_d  = state_q;
        drain_to = 1'b0;
        if (state_q != StLinkDown && !link_up_i) begin
            state_d = StLinkDown;
        end else begin
            unique case (state_q)
                StLinkDown: begin
                    if (deb_stable && deb_link) state_d = StReset;
                end
                StActive: begin
                    if (deb_stable && deb_link && (deb_speed != sel_1000m_o)) state_d = StDrain;
                end
                StDrain: begin
                    // Idle wins over a coincident timeout, so no pulse in that case.
                    if (!tx_busy_i && !rx_busy_i) begin
                        state_d = StReset;
                    end else if (phase_q == PhaseW'(DRAIN_TIMEOUT - 1)) begin
                        state_d  = StReset;
                        drain_to = 1'b1;
                    end
                end
                StReset: begin
                    if (phase_q == PhaseW'(RST_CYCLES - 1)) state_d = StSettle;
                end
                StSettle: begin
                    if (phase_q == PhaseW'(SETTLE_CYCLES - 1)) state_d = StActive;
                end
                default: state_d = StLinkDown;
            endcase
        end
    end

    // Phase counter clears on every state change and only runs in timed states.
    always_comb begin
        phase_d = '0;
        if (state_d == state_q &&
            (state_q == StDrain || state_q == StReset || state_q == StSettle)) begin
            phase_d = phase_q + 1'b1;
        end
    end

    // Outputs decoded from the next state so they switch with the state register.
    always_comb begin
        dp_rst_d        = (state_d == StLinkDown) || (state_d == StReset);
        tx_hold_d       = (state_d != StActive);
        change_done_d   = (state_d == StActive) && (state_q != StActive);
        drain_timeout_d = drain_to;
        sel_d           = sel_1000m_o;
        // Speed select moves only while the datapath is entering reset.
        if (state_d == StReset && state_q != StReset) sel_d = deb_speed;
    end

    // Output registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sel_1000m_o     <= 1'b0;
            dp_rst_o        <= 1'b1;
            tx_hold_o       <= 1'b1;
            change_done_o   <= 1'b0;
            drain_timeout_o <= 1'b0;
        end else begin
            sel_1000m_o     <= sel_d;
            dp_rst_o        <= dp_rst_d;
            tx_hold_o       <= tx_hold_d;
            change_done_o   <= change_done_d;
            drain_timeout_o <= drain_timeout_d;
        end
    end

endmodule

// File: tb/tb_rgmii_speed_ctrl.sv
// Self-checking bench for rgmii_speed_ctrl with default parameters.
module tb_rgmii_speed_ctrl;

    logic clk = 1'b0;
    logic rst;
    logic link_up, speed, tx_busy, rx_busy;
    logic sel, dp_rst, tx_hold, change_done, drain_timeout;

    rgmii_speed_ctrl u_dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .link_up_i      (link_up),
        .speed_1000m_i  (speed),
        .tx_busy_i      (tx_busy),
        .rx_busy_i      (rx_busy),
        .sel_1000m_o    (sel),
        .dp_rst_o       (dp_rst),
        .tx_hold_o      (tx_hold),
        .change_done_o  (change_done),
        .drain_timeout_o(drain_timeout)
    );

    always #5 clk = ~clk;

    // Expected outputs packed as {sel, dp_rst, tx_hold, change_done, drain_timeout}.
    typedef struct {
        string      name;
        bit         link;
        bit         sp;
        bit         txb;
        bit         rxb;
        int         n;
        logic [4:0] exp;
    } vec_t;

    vec_t       tbl[$];
    logic [4:0] sb_q[$];
    int         total = 0;
    int         bad = 0;
    int         cd_cnt = 0;
    int         dto_cnt = 0;

    // Pulse counters sampled mid-cycle.
    always @(negedge clk) begin
        if (change_done === 1'b1) cd_cnt++;
        if (drain_timeout === 1'b1) dto_cnt++;
    end

    function automatic vec_t mk(string name, bit l, bit s, bit t, bit r, int n, logic [4:0] e);
        vec_t v;
        v.name = name; v.link = l; v.sp = s; v.txb = t; v.rxb = r; v.n = n; v.exp = e;
        return v;
    endfunction

    function automatic logic [4:0] outs();
        return {sel, dp_rst, tx_hold, change_done, drain_timeout};
    endfunction

    task automatic check(string name, logic [4:0] act, logic [4:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got {sel,rst,hold,done,to}=%b want %b at %0t", name, act, exp,
                     $time);
        end
    endtask

    task automatic check_int(string name, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    // Drive a vector, queue its expectation, run n edges, then compare against the queue.
    task automatic apply(vec_t v);
        link_up = v.link; speed = v.sp; tx_busy = v.txb; rx_busy = v.rxb;
        sb_q.push_back(v.exp);
        repeat (v.n) @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            total++; bad++;
            $display("FAIL %s: scoreboard empty", v.name);
        end else begin
            check(v.name, outs(), sb_q.pop_front());
        end
    endtask

    initial begin
        // Link-up at 1000M from reset.
        tbl.push_back(mk("ld_hold",      1, 1, 0, 0, 16, 5'b01100));
        tbl.push_back(mk("rst_entry",    1, 1, 0, 0, 1,  5'b11100));
        tbl.push_back(mk("rst_last",     1, 1, 0, 0, 7,  5'b11100));
        tbl.push_back(mk("settle_entry", 1, 1, 0, 0, 1,  5'b10100));
        tbl.push_back(mk("settle_last",  1, 1, 0, 0, 7,  5'b10100));
        tbl.push_back(mk("active_entry", 1, 1, 0, 0, 1,  5'b10010));
        tbl.push_back(mk("active_hold",  1, 1, 0, 0, 1,  5'b10000));
        // Drop to 10/100 while TX busy; reset follows busy release.
        tbl.push_back(mk("dn_dbnc",      1, 0, 1, 0, 16, 5'b10000));
        tbl.push_back(mk("dn_drain",     1, 0, 1, 0, 1,  5'b10100));
        tbl.push_back(mk("dn_busy",      1, 0, 1, 0, 32, 5'b10100));
        tbl.push_back(mk("dn_idle_rst",  1, 0, 0, 0, 1,  5'b01100));
        tbl.push_back(mk("dn_rst_last",  1, 0, 0, 0, 7,  5'b01100));
        tbl.push_back(mk("dn_settle",    1, 0, 0, 0, 1,  5'b00100));
        tbl.push_back(mk("dn_active",    1, 0, 0, 0, 8,  5'b00010));
        tbl.push_back(mk("dn_done_off",  1, 0, 0, 0, 1,  5'b00000));
        // Drain timeout with RX held busy.
        tbl.push_back(mk("to_dbnc",      1, 1, 0, 1, 16, 5'b00000));
        tbl.push_back(mk("to_drain",     1, 1, 0, 1, 1,  5'b00100));
        tbl.push_back(mk("to_wait",      1, 1, 0, 1, 4094, 5'b00100));
        tbl.push_back(mk("to_last",      1, 1, 0, 1, 1,  5'b00100));
        tbl.push_back(mk("to_pulse",     1, 1, 0, 1, 1,  5'b11101));
        tbl.push_back(mk("to_pulse_off", 1, 1, 0, 1, 1,  5'b11100));
        tbl.push_back(mk("to_rst_last",  1, 1, 0, 0, 6,  5'b11100));
        tbl.push_back(mk("to_settle",    1, 1, 0, 0, 1,  5'b10100));
        tbl.push_back(mk("to_active",    1, 1, 0, 0, 8,  5'b10010));
        tbl.push_back(mk("to_done_off",  1, 1, 0, 0, 1,  5'b10000));
        // Idle arriving on the timeout cycle counts as idle.
        tbl.push_back(mk("tie_dbnc",     1, 0, 1, 0, 16, 5'b10000));
        tbl.push_back(mk("tie_drain",    1, 0, 1, 0, 1,  5'b10100));
        tbl.push_back(mk("tie_last",     1, 0, 1, 0, 4095, 5'b10100));
        tbl.push_back(mk("tie_rst",      1, 0, 0, 0, 1,  5'b01100));
        tbl.push_back(mk("tie_rst_last", 1, 0, 0, 0, 7,  5'b01100));
        tbl.push_back(mk("tie_settle",   1, 0, 0, 0, 1,  5'b00100));
        tbl.push_back(mk("tie_active",   1, 0, 0, 0, 8,  5'b00010));
        tbl.push_back(mk("tie_done_off", 1, 0, 0, 0, 1,  5'b00000));
        // Speed returns to the current select during DRAIN; sequence still completes.
        tbl.push_back(mk("back_dbnc",    1, 1, 1, 0, 16, 5'b00000));
        tbl.push_back(mk("back_drain",   1, 1, 1, 0, 1,  5'b00100));
        tbl.push_back(mk("back_revert",  1, 0, 1, 0, 20, 5'b00100));
        tbl.push_back(mk("back_rst",     1, 0, 0, 0, 1,  5'b01100));
        tbl.push_back(mk("back_rst_last", 1, 0, 0, 0, 7, 5'b01100));
        tbl.push_back(mk("back_settle",  1, 0, 0, 0, 1,  5'b00100));
        tbl.push_back(mk("back_active",  1, 0, 0, 0, 8,  5'b00010));
        tbl.push_back(mk("back_done_off", 1, 0, 0, 0, 1, 5'b00000));
        // Link drop during SETTLE.
        tbl.push_back(mk("ls_dbnc",      1, 1, 0, 0, 16, 5'b00000));
        tbl.push_back(mk("ls_drain",     1, 1, 0, 0, 1,  5'b00100));
        tbl.push_back(mk("ls_rst",       1, 1, 0, 0, 1,  5'b11100));
        tbl.push_back(mk("ls_rst_last",  1, 1, 0, 0, 7,  5'b11100));
        tbl.push_back(mk("ls_settle",    1, 1, 0, 0, 1,  5'b10100));
        tbl.push_back(mk("ls_settle_mid", 1, 1, 0, 0, 3, 5'b10100));
        tbl.push_back(mk("ls_linkdown",  0, 1, 0, 0, 1,  5'b11100));
        tbl.push_back(mk("ls_stay_down", 0, 1, 0, 0, 12, 5'b11100));
        // Relink and enter DRAIN for the async reset test.
        tbl.push_back(mk("rl_hold",      1, 1, 0, 0, 16, 5'b11100));
        tbl.push_back(mk("rl_rst",       1, 1, 0, 0, 1,  5'b11100));
        tbl.push_back(mk("rl_rst_last",  1, 1, 0, 0, 7,  5'b11100));
        tbl.push_back(mk("rl_settle",    1, 1, 0, 0, 1,  5'b10100));
        tbl.push_back(mk("rl_settle_last", 1, 1, 0, 0, 7, 5'b10100));
        tbl.push_back(mk("rl_active",    1, 1, 0, 0, 1,  5'b10010));
        tbl.push_back(mk("rl_dbnc",      1, 0, 1, 0, 16, 5'b10000));
        tbl.push_back(mk("rl_drain",     1, 0, 1, 0, 1,  5'b10100));
        tbl.push_back(mk("rl_drain_mid", 1, 0, 1, 0, 5,  5'b10100));

        rst = 1'b1; link_up = 1'b0; speed = 1'b0; tx_busy = 1'b0; rx_busy = 1'b0;
        #1;
        check("reset_vals", outs(), 5'b01100);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        foreach (tbl[i]) apply(tbl[i]);
        check_int("done_pulses_table", cd_cnt, 6);
        check_int("timeout_pulses_table", dto_cnt, 1);

        // Asynchronous reset in the middle of DRAIN.
        #3 rst = 1'b1;
        #1;
        check("async_rst", outs(), 5'b01100);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        apply(mk("post_rst_hold",   1, 1, 0, 0, 16, 5'b01100));
        apply(mk("post_rst_reset",  1, 1, 0, 0, 1,  5'b11100));
        apply(mk("post_rst_settle", 1, 1, 0, 0, 8,  5'b10100));
        apply(mk("post_rst_active", 1, 1, 0, 0, 8,  5'b10010));
        apply(mk("post_rst_steady", 1, 1, 0, 0, 1,  5'b10000));
        check_int("done_pulses_relink", cd_cnt, 7);

        // Speed status chattering every 5 cycles never debounces.
        for (int i = 0; i < 40; i++) begin
            apply(mk("chatter", 1, (i % 2 == 1), 0, 0, 5, 5'b10000));
        end
        apply(mk("chatter_after", 1, 1, 0, 0, 20, 5'b10000));
        check_int("done_pulses_final", cd_cnt, 7);
        check_int("timeout_pulses_final", dto_cnt, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
